// File: rtl/mdu_pkg.sv
// Shared types for the RV32M multiply/divide sequencer.
// Operation codes, FSM states and ALU function codes.
package mdu_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_ITER,
        S_FIX_LO,
        S_FIX_HI,
        S_DONE
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    // rs1 is read as two's complement
    function automatic logic a_is_signed(funct3_e f);
        return f inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    // rs2 is read as two's complement
    function automatic logic b_is_signed(funct3_e f);
        return f inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response and shared-ALU signals of the sequencer.
// master: execute side plus ALU; slave: the sequencer.
interface mdu_sequencer_if;

    logic        start;
    logic        ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;

    modport master (
        output start, funct3, op_a, op_b, flush,
        output alu_result, alu_zero,
        input  ready, busy, done, result,
        input  alu_op1, alu_op2, alu_ctrl
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        input  alu_result, alu_zero,
        output ready, busy, done, result,
        output alu_op1, alu_op2, alu_ctrl
    );

endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M sequencer: fixed 37-cycle mul/div/rem
// built on the shared ALU's add and subtract only.
module mdu_sequencer
    import mdu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    mdu_sequencer_if.slave mdu
);

    state_e      r_state;
    state_e      w_next;
    funct3_e     r_f3;
    logic [4:0]  r_k;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_raw_a;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_result;
    logic        r_sa;
    logic        r_sb;
    logic        r_dz;
    logic        r_lz;
    logic        r_done;

    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [3:0]  w_ctrl;
    logic [31:0] w_sum;
    logic [31:0] w_sh;
    logic [31:0] w_bmag;
    logic [31:0] w_hi_fin;
    logic [31:0] w_sel;
    logic        w_accept;
    logic        w_div;
    logic        w_neg;
    logic        w_hi_fix;
    logic        w_carry;
    logic        w_borrow;
    logic        w_take;

    assign w_sum    = mdu.alu_result;
    assign w_div    = r_f3[2];
    assign w_neg    = r_sa ^ r_sb;
    assign w_hi_fix = w_div ? r_sa : w_neg;
    assign w_sh     = {r_hi[30:0], r_lo[31]};
    assign w_bmag   = r_sb ? w_sum : r_b;
    assign w_hi_fin = w_hi_fix ? w_sum : r_hi;

    // 33rd bit of hi + |a|
    assign w_carry = (r_hi[31] & r_a[31])
                   | ((r_hi[31] | r_a[31]) & ~w_sum[31]);

    // borrow out of sh - |b|
    assign w_borrow = (~w_sh[31] & r_b[31])
                    | ((~w_sh[31] | r_b[31]) & w_sum[31]);

    // shifted-out rem bit makes the partial remainder exceed |b|
    assign w_take = r_hi[31] | ~w_borrow;

    // the retiring cycle also takes a new request so ops can issue back-to-back
    assign w_accept = mdu.start & ~mdu.flush
                    & ((r_state == S_IDLE) | (r_state == S_DONE));

    assign mdu.ready    = (r_state == S_IDLE);
    assign mdu.busy     = (r_state != S_IDLE);
    assign mdu.done     = r_done;
    assign mdu.result   = r_result;
    assign mdu.alu_op1  = w_op1;
    assign mdu.alu_op2  = w_op2;
    assign mdu.alu_ctrl = w_ctrl;

    // Final result selection, evaluated while the high word is fixed up
    always_comb begin
        w_sel = r_lo;
        unique case (r_f3)
            F3_MUL:                       w_sel = r_lo;
            F3_MULH, F3_MULHSU, F3_MULHU: w_sel = w_hi_fin;
            F3_DIV, F3_DIVU:              w_sel = r_dz ? '1 : r_lo;
            default:                      w_sel = r_dz ? r_raw_a : w_hi_fin;
        endcase
    end

    // Next state and ALU operand/function drive
    always_comb begin
        w_next = r_state;
        w_op1  = '0;
        w_op2  = '0;
        w_ctrl = ALU_ADD;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_ABS_A;
            end
            S_ABS_A: begin
                w_op2  = r_a;
                w_ctrl = ALU_SUB;
                w_next = S_ABS_B;
            end
            S_ABS_B: begin
                w_op2  = r_b;
                w_ctrl = ALU_SUB;
                w_next = S_ITER;
            end
            S_ITER: begin
                if (w_div) begin
                    w_op1  = w_sh;
                    w_op2  = r_b;
                    w_ctrl = ALU_SUB;
                end else begin
                    w_op1 = r_hi;
                    w_op2 = r_a;
                end
                if (r_k == 5'd31) w_next = S_FIX_LO;
            end
            S_FIX_LO: begin
                w_op2  = r_lo;
                w_ctrl = ALU_SUB;
                w_next = S_FIX_HI;
            end
            S_FIX_HI: begin
                if (w_div) begin
                    w_op2  = r_hi;
                    w_ctrl = ALU_SUB;
                end else begin
                    w_op1 = ~r_hi;
                    w_op2 = {31'b0, r_lz};
                end
                w_next = S_DONE;
            end
            S_DONE: begin
                w_next = w_accept ? S_ABS_A : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (mdu.flush && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Operand capture, shift-add / restoring-divide datapath, result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f3     <= F3_MUL;
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_raw_a  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dz     <= 1'b0;
            r_lz     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (w_next == S_DONE);
            if (w_accept) begin
                r_f3    <= funct3_e'(mdu.funct3);
                r_a     <= mdu.op_a;
                r_b     <= mdu.op_b;
                r_raw_a <= mdu.op_a;
                r_sa    <= mdu.op_a[31] & a_is_signed(funct3_e'(mdu.funct3));
                r_sb    <= mdu.op_b[31] & b_is_signed(funct3_e'(mdu.funct3));
                r_dz    <= mdu.funct3[2] & (mdu.op_b == '0);
            end else begin
                case (r_state)
                    S_ABS_A: begin
                        if (r_sa) r_a <= w_sum;
                    end
                    S_ABS_B: begin
                        r_b  <= w_bmag;
                        r_hi <= '0;
                        r_lo <= w_div ? r_a : w_bmag;
                        r_k  <= '0;
                    end
                    S_ITER: begin
                        r_k <= r_k + 5'd1;
                        if (w_div) begin
                            r_hi <= w_take ? w_sum : w_sh;
                            r_lo <= {r_lo[30:0], w_take};
                        end else if (r_lo[0]) begin
                            r_hi <= {w_carry, w_sum[31:1]};
                            r_lo <= {w_sum[0], r_lo[31:1]};
                        end else begin
                            r_hi <= {1'b0, r_hi[31:1]};
                            r_lo <= {r_hi[0], r_lo[31:1]};
                        end
                    end
                    S_FIX_LO: begin
                        r_lz <= (r_lo == '0);
                        if (w_neg) r_lo <= w_sum;
                    end
                    S_FIX_HI: begin
                        r_hi <= w_hi_fin;
                        if (!mdu.flush) r_result <= w_sel;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer with a behavioural ALU
// and a 64-bit arithmetic reference for all RV32M ops.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mdu_sequencer_if mif ();

    mdu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (mif)
    );

    assign mif.alu_result = (mif.alu_ctrl == 4'b1000)
                          ? mif.alu_op1 - mif.alu_op2
                          : mif.alu_op1 + mif.alu_op2;
    assign mif.alu_zero = (mif.alu_result == 32'd0);

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = 32'd0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        r  = 32'd0;
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            3'd1: begin
                x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b};
                p = x * y; r = p[63:32];
            end
            3'd2: begin
                x = {{32{a[31]}}, a}; y = {32'd0, b};
                p = x * y; r = p[63:32];
            end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = sa / sb;
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = sa % sb;
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && mif.done) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_done: got result 0x%08h expected no done",
                         mif.result);
            end else begin
                chk("result", mif.result, exp_q.pop_front());
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(mif.ready), 32'd1);
        chk({tag, "_busy"}, 32'(mif.busy), 32'd0);
        chk({tag, "_done"}, 32'(mif.done), 32'd0);
        chk({tag, "_result"}, mif.result, 32'd0);
        chk({tag, "_alu_op1"}, mif.alu_op1, 32'd0);
        chk({tag, "_alu_op2"}, mif.alu_op2, 32'd0);
        chk({tag, "_alu_ctrl"}, 32'(mif.alu_ctrl), 32'd0);
    endtask

    // Called at a negedge in IDLE or in the done cycle; returns at the
    // negedge of the done cycle.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int hold);
        int  n;
        int  busy_low;
        bit  got;
        mif.funct3 = f;
        mif.op_a   = a;
        mif.op_b   = b;
        mif.start  = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        last_res = exp;
        if (hold == 0) begin
            mif.start = 1'b0;
        end else begin
            mif.funct3 = 3'($urandom_range(0, 7));
            mif.op_a   = $urandom;
            mif.op_b   = $urandom;
        end
        n        = 0;
        busy_low = 0;
        got      = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            n = i;
            if (hold > 0 && i == hold) mif.start = 1'b0;
            if (!mif.busy) busy_low++;
            if (mif.done) got = 1'b1;
        end
        mif.start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("done_latency", 32'(n), 32'd36);
        chk("busy_through_run", 32'(busy_low), 32'd0);
    endtask

    task automatic after_op();
        @(negedge clk);
        chk("idle_ready", 32'(mif.ready), 32'd1);
        chk("done_one_cycle", 32'(mif.done), 32'd0);
        chk("idle_busy", 32'(mif.busy), 32'd0);
    endtask

    logic [2:0]  d_f[13];
    logic [31:0] d_a[13];
    logic [31:0] d_b[13];
    logic [31:0] d_e[13];

    initial begin
        d_f[0]  = 3'd0; d_a[0]  = 32'd7;         d_b[0]  = 32'hFFFFFFFD; d_e[0]  = 32'hFFFFFFEB;
        d_f[1]  = 3'd3; d_a[1]  = 32'hFFFFFFFF;  d_b[1]  = 32'hFFFFFFFF; d_e[1]  = 32'hFFFFFFFE;
        d_f[2]  = 3'd1; d_a[2]  = 32'h80000000;  d_b[2]  = 32'h80000000; d_e[2]  = 32'h40000000;
        d_f[3]  = 3'd2; d_a[3]  = 32'hFFFFFFFF;  d_b[3]  = 32'hFFFFFFFF; d_e[3]  = 32'hFFFFFFFF;
        d_f[4]  = 3'd4; d_a[4]  = 32'hFFFFFFF9;  d_b[4]  = 32'd2;        d_e[4]  = 32'hFFFFFFFD;
        d_f[5]  = 3'd6; d_a[5]  = 32'hFFFFFFF9;  d_b[5]  = 32'd2;        d_e[5]  = 32'hFFFFFFFF;
        d_f[6]  = 3'd5; d_a[6]  = 32'd100;       d_b[6]  = 32'd7;        d_e[6]  = 32'd14;
        d_f[7]  = 3'd7; d_a[7]  = 32'd100;       d_b[7]  = 32'd7;        d_e[7]  = 32'd2;
        d_f[8]  = 3'd4; d_a[8]  = 32'd5;         d_b[8]  = 32'd0;        d_e[8]  = 32'hFFFFFFFF;
        d_f[9]  = 3'd6; d_a[9]  = 32'd5;         d_b[9]  = 32'd0;        d_e[9]  = 32'd5;
        d_f[10] = 3'd5; d_a[10] = 32'h80000000;  d_b[10] = 32'd0;        d_e[10] = 32'hFFFFFFFF;
        d_f[11] = 3'd4; d_a[11] = 32'h80000000;  d_b[11] = 32'hFFFFFFFF; d_e[11] = 32'h80000000;
        d_f[12] = 3'd6; d_a[12] = 32'h80000000;  d_b[12] = 32'hFFFFFFFF; d_e[12] = 32'd0;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          dn;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        rst_n      = 1'b0;
        mif.start  = 1'b0;
        mif.flush  = 1'b0;
        mif.funct3 = 3'd0;
        mif.op_a   = 32'd0;
        mif.op_b   = 32'd0;
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            do_op(d_f[i], d_a[i], d_b[i], d_e[i], 0);
            after_op();
        end

        // start held high while busy is not taken again
        do_op(3'd5, 32'd1000, 32'd10, 32'd100, 30);
        after_op();

        // back-to-back: second request presented in the done cycle
        do_op(3'd0, 32'd3, 32'd5, 32'd15, 0);
        do_op(3'd5, 32'd50, 32'd5, 32'd10, 0);
        after_op();

        // flush at ITER k=10
        mif.funct3 = 3'd5;
        mif.op_a   = 32'd77;
        mif.op_b   = 32'd7;
        mif.start  = 1'b1;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        repeat (13) @(negedge clk);
        chk("flush_pre_busy", 32'(mif.busy), 32'd1);
        mif.flush = 1'b1;
        @(posedge clk);
        #1;
        mif.flush = 1'b0;
        chk("flush_ready", 32'(mif.ready), 32'd1);
        chk("flush_busy", 32'(mif.busy), 32'd0);
        chk("flush_result", mif.result, last_res);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mif.done) dn++;
        end
        chk("flush_no_done", 32'(dn), 32'd0);

        // flush beats start in IDLE
        mif.funct3 = 3'd0;
        mif.op_a   = 32'd9;
        mif.op_b   = 32'd9;
        mif.start  = 1'b1;
        mif.flush  = 1'b1;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        mif.flush = 1'b0;
        chk("flush_prio_ready", 32'(mif.ready), 32'd1);
        @(negedge clk);
        chk("flush_prio_busy", 32'(mif.busy), 32'd0);

        // asynchronous reset at ITER k=20
        mif.funct3 = 3'd1;
        mif.op_a   = 32'h1234_5678;
        mif.op_b   = 32'h9ABC_DEF0;
        mif.start  = 1'b1;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        repeat (23) @(negedge clk);
        chk("pre_reset_ctrl", 32'(mif.alu_ctrl), 32'd0);
        chk("pre_reset_busy", 32'(mif.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        last_res = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 250; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            do_op(f, a, b, ref_model(f, a, b), 0);
            if ($urandom_range(0, 1) == 0 || i == 249) after_op();
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
